// File: rtl/stage_if_prefetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// handshake, and the decode-facing queue head.
//   master : the fetch stage (drives imem requests and the dec_* head)
//   slave  : the environment (PC-select, instruction memory, decode)
interface stage_if_prefetch_if #(
  parameter int XLEN = 32
);
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_fault;

  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pcplus4;
  logic [31:0]     dec_inst;
  logic            dec_trap_valid;
  logic [1:0]      dec_trap_cause;
  logic            busy;

  modport master (
    input  redir_valid, redir_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
    input  dec_ready,
    output imem_req_valid, imem_req_addr,
    output dec_valid, dec_pc, dec_pcplus4, dec_inst, dec_trap_valid,
    output dec_trap_cause, busy
  );

  modport slave (
    output redir_valid, redir_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
    output dec_ready,
    input  imem_req_valid, imem_req_addr,
    input  dec_valid, dec_pc, dec_pcplus4, dec_inst, dec_trap_valid,
    input  dec_trap_cause, busy
  );
endinterface

// File: rtl/stage_if_prefetch.sv
// Prefetching instruction-fetch stage.
// Generates sequential fetch PCs, issues them to instruction memory over a
// valid/ready request channel, collects in-order responses into a DEPTH-entry
// queue and presents the queue head to decode. Redirects flush the queue and
// discard responses still in flight; a misaligned PC or an access fault
// queues a single trap entry and stops fetching until the next redirect.
// Ports:
//   clk    : clock
//   start  : synchronous active-low reset (0 = reset, 1 = run)
//   bus    : stage_if_prefetch_if.master (redirect, imem req/rsp, decode head, busy)
module stage_if_prefetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic                 clk,
  input logic                 start,
  stage_if_prefetch_if.master bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   OUTST_C = CW'(MAX_OUTST);
  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [1:0]      CAUSE_NONE     = 2'd0;
  localparam logic [1:0]      CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0]      CAUSE_FAULT    = 2'd2;

  typedef enum logic {RUN, HALT} state_t;

  // Control state
  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW-1:0]   fl_rd, fl_wr;

  // Prefetch queue storage and the PC of every in-flight request (issue order)
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_inst  [DEPTH];
  logic [1:0]      q_cause [DEPTH];
  logic [XLEN-1:0] fl_pc   [DEPTH];

  logic            running, aligned, room;
  logic [CW:0]     occ;
  logic            issue, rsp, rsp_keep, misal_push, push, pop, head_valid;
  logic [XLEN-1:0] push_pc;
  logic [31:0]     push_inst;
  logic [1:0]      push_cause;
  logic [CW-1:0]   outst_n;

  always_comb begin
    running    = start && (state == RUN) && !bus.redir_valid;
    aligned    = (fetch_pc[1:0] == 2'b00);
    // Queue space is reserved for every request still in flight, so a
    // response can always be accepted without backpressure.
    occ        = {1'b0, count} + {1'b0, outst};
    room       = occ < {1'b0, DEPTH_C};
    bus.imem_req_valid = running && aligned && room && (outst < OUTST_C);
    bus.imem_req_addr  = fetch_pc;
    issue      = bus.imem_req_valid && bus.imem_req_ready;

    rsp        = start && bus.imem_rsp_valid;
    rsp_keep   = rsp && !bus.redir_valid && (drop == '0);
    // The misaligned trap waits until every older response has landed.
    misal_push = running && !aligned && room && (outst == '0);
    push       = rsp_keep || misal_push;

    push_pc    = misal_push ? fetch_pc : fl_pc[fl_rd];
    push_inst  = (rsp_keep && !bus.imem_rsp_fault) ? bus.imem_rsp_data : NOP;
    push_cause = misal_push ? CAUSE_MISALIGN :
                 (bus.imem_rsp_fault ? CAUSE_FAULT : CAUSE_NONE);

    head_valid = (count != '0);
    pop        = head_valid && bus.dec_ready && !bus.redir_valid;
    outst_n    = outst + CW'(issue) - CW'(rsp);

    bus.dec_valid      = head_valid;
    bus.dec_pc         = head_valid ? q_pc[rd_ptr] : '0;
    bus.dec_pcplus4    = head_valid ? q_pc[rd_ptr] + XLEN'(4) : '0;
    bus.dec_inst       = head_valid ? q_inst[rd_ptr] : '0;
    bus.dec_trap_cause = head_valid ? q_cause[rd_ptr] : CAUSE_NONE;
    bus.dec_trap_valid = head_valid && (q_cause[rd_ptr] != CAUSE_NONE);
    bus.busy           = (outst != '0) || (count != '0);
  end

  // Control path: FSM, counters, pointers
  always_ff @(posedge clk) begin
    if (!start) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fl_rd    <= '0;
      fl_wr    <= '0;
    end else begin
      outst <= outst_n;
      if (issue) fl_wr <= fl_wr + AW'(1);
      if (rsp)   fl_rd <= fl_rd + AW'(1);

      if (bus.redir_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        state    <= RUN;
        fetch_pc <= bus.redir_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop     <= outst_n;
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)  wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);

        if (rsp && (drop != '0)) begin
          drop <= drop - CW'(1);
        end else if (rsp_keep && bus.imem_rsp_fault) begin
          // Younger requests behind the faulting one must never reach decode.
          drop  <= outst_n;
          state <= HALT;
        end
        if (misal_push) state <= HALT;
      end
    end
  end

  // Data path: queue and in-flight PC storage, not reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= push_pc;
      q_inst[wr_ptr]  <= push_inst;
      q_cause[wr_ptr] <= push_cause;
    end
    if (issue) fl_pc[fl_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
module tb_stage_if_prefetch;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] DKEY = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic start;
  always #5 clk = ~clk;

  stage_if_prefetch_if #(.XLEN(XLEN)) bus ();

  stage_if_prefetch #(
    .XLEN(XLEN), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .start(start),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  cause;
  } exp_t;
  exp_t exp_q[$];

  // Instruction memory: always ready, fixed latency of mem_lat cycles (1..3)
  int          mem_lat   = 1;
  logic        fault_en  = 1'b0;
  logic [31:0] fault_addr = '0;
  logic [2:0]  p_v;
  logic [31:0] p_a [3];
  int          cyc_cnt = 0;
  logic [31:0] req_log[$];
  int          req_cyc[$];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!start) begin
      p_v <= 3'b000;
    end else begin
      p_v    <= {p_v[1:0], bus.imem_req_valid & bus.imem_req_ready};
      p_a[0] <= bus.imem_req_addr;
      p_a[1] <= p_a[0];
      p_a[2] <= p_a[1];
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        req_log.push_back(bus.imem_req_addr);
        req_cyc.push_back(cyc_cnt);
      end
    end
  end

  assign bus.imem_rsp_valid = p_v[mem_lat-1];
  assign bus.imem_rsp_data  = p_a[mem_lat-1] ^ DKEY;
  assign bus.imem_rsp_fault = p_v[mem_lat-1] & fault_en & (p_a[mem_lat-1] == fault_addr);

  function automatic void expect_entry(input logic [31:0] pc, input logic [1:0] cause);
    exp_t e;
    e.pc    = pc;
    e.cause = cause;
    e.inst  = (cause != 2'd0) ? NOP : (pc ^ DKEY);
    exp_q.push_back(e);
  endfunction

  task automatic redirect(input logic [31:0] target);
    @(negedge clk);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = target;
    exp_q.delete();
    req_log.delete();
    req_cyc.delete();
    @(negedge clk);
    bus.redir_valid = 1'b0;
  endtask

  // Let decode stall until the queue is full and nothing is in flight.
  task automatic quiesce();
    bus.dec_ready = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Decode side of the scoreboard: pops one expected entry per accepted head.
  task automatic drain_and_score(input int n, input int budget, input string tag);
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.dec_ready = 1'b1;
      #1;
      if (bus.dec_valid) begin
        e = exp_q.pop_front();
        total++;
        if (bus.dec_pc !== e.pc) begin
          bad++; $display("FAIL %s dec_pc: got %h want %h", tag, bus.dec_pc, e.pc);
        end
        total++;
        if (bus.dec_pcplus4 !== e.pc + 32'd4) begin
          bad++; $display("FAIL %s dec_pcplus4: got %h want %h", tag, bus.dec_pcplus4, e.pc + 32'd4);
        end
        total++;
        if (bus.dec_inst !== e.inst) begin
          bad++; $display("FAIL %s dec_inst: got %h want %h", tag, bus.dec_inst, e.inst);
        end
        total++;
        if (bus.dec_trap_cause !== e.cause || bus.dec_trap_valid !== (e.cause != 2'd0)) begin
          bad++; $display("FAIL %s trap: got v=%b c=%0d want c=%0d", tag,
                          bus.dec_trap_valid, bus.dec_trap_cause, e.cause);
        end
        got++;
      end
    end
    total++;
    if (got != n) begin
      bad++; $display("FAIL %s drain_timeout: got %0d entries want %0d", tag, got, n);
    end
    @(negedge clk);
    bus.dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    bus.dec_ready = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL reset_req: got v=%b a=%h want v=0 a=0", bus.imem_req_valid, bus.imem_req_addr);
    end
    total++;
    if (bus.dec_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dec_trap_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dec: got v=%b busy=%b trap=%b want 0", bus.dec_valid, bus.busy, bus.dec_trap_valid);
    end
    total++;
    if (bus.dec_pc !== 32'h0 || bus.dec_inst !== 32'h0 || bus.dec_trap_cause !== 2'd0) begin
      bad++; $display("FAIL reset_head: got pc=%h inst=%h c=%0d want 0", bus.dec_pc, bus.dec_inst, bus.dec_trap_cause);
    end
    req_log.delete();
    req_cyc.delete();
    start = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) expect_entry(32'(i * 4), 2'd0);
    drain_and_score(6, 40, "b2b");
    total++;
    if (req_log.size() < 3) begin
      bad++; $display("FAIL b2b_reqcount: got %0d want >=3", req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (req_log[i] !== 32'(i * 4)) begin
          bad++; $display("FAIL b2b_addr%0d: got %h want %h", i, req_log[i], 32'(i * 4));
        end
      end
      for (int i = 0; i < 2; i++) begin
        total++;
        if (req_cyc[i+1] - req_cyc[i] != 1) begin
          bad++; $display("FAIL b2b_gap%0d: got %0d want 1", i, req_cyc[i+1] - req_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    quiesce();
    redirect(32'h0);
    repeat (10) @(negedge clk);
    total++;
    if (req_log.size() != 4) begin
      bad++; $display("FAIL stall_reqs: got %0d want 4", req_log.size());
    end
    total++;
    if (bus.imem_req_valid !== 1'b0 || bus.dec_valid !== 1'b1) begin
      bad++; $display("FAIL stall_state: got req_v=%b dec_v=%b want 0 1", bus.imem_req_valid, bus.dec_valid);
    end
    for (int i = 0; i < 4; i++) expect_entry(32'(i * 4), 2'd0);
    drain_and_score(4, 20, "stall");
  endtask

  task automatic test_redirect_stale();
    quiesce();
    mem_lat = 3;
    redirect(32'h40);
    @(negedge clk);
    // two requests (0x40, 0x44) are in flight here, neither answered
    redirect(32'h100);
    for (int i = 0; i < 4; i++) expect_entry(32'h100 + 32'(i * 4), 2'd0);
    drain_and_score(4, 60, "redir");
    total++;
    if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
      bad++; $display("FAIL redir_first_req: got %h want 00000100",
                      (req_log.size() != 0) ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_misaligned();
    int seen = 0;
    quiesce();
    mem_lat = 1;
    redirect(32'h102);
    expect_entry(32'h102, 2'd1);
    drain_and_score(1, 20, "misal");
    bus.dec_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.dec_valid) seen++;
    end
    total++;
    if (seen != 0 || req_log.size() != 0) begin
      bad++; $display("FAIL misal_halt: got entries=%0d reqs=%0d want 0 0", seen, req_log.size());
    end
    redirect(32'h200);
    for (int i = 0; i < 3; i++) expect_entry(32'h200 + 32'(i * 4), 2'd0);
    drain_and_score(3, 30, "misal_resume");
  endtask

  task automatic test_fault();
    int seen = 0;
    quiesce();
    fault_en = 1'b1;
    fault_addr = 32'h8;
    redirect(32'h0);
    expect_entry(32'h0, 2'd0);
    expect_entry(32'h4, 2'd0);
    expect_entry(32'h8, 2'd2);
    drain_and_score(3, 30, "fault");
    bus.dec_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.dec_valid) seen++;
    end
    total++;
    if (seen != 0 || req_log.size() != 4) begin
      bad++; $display("FAIL fault_halt: got entries=%0d reqs=%0d want 0 4", seen, req_log.size());
    end
    fault_en = 1'b0;
    redirect(32'h300);
    expect_entry(32'h300, 2'd0);
    expect_entry(32'h304, 2'd0);
    drain_and_score(2, 20, "fault_resume");
  endtask

  task automatic test_wrap_and_midreset();
    quiesce();
    redirect(32'hFFFF_FFF8);
    expect_entry(32'hFFFF_FFF8, 2'd0);
    expect_entry(32'hFFFF_FFFC, 2'd0);
    expect_entry(32'h0000_0000, 2'd0);
    expect_entry(32'h0000_0004, 2'd0);
    drain_and_score(4, 30, "wrap");
    total++;
    if (req_log.size() < 3 || req_log[2] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got %h want 00000000",
                      (req_log.size() >= 3) ? req_log[2] : 32'hx);
    end
    bus.dec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.dec_valid !== 1'b0 || bus.busy !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL midreset: got dec_v=%b busy=%b req_v=%b want 0", bus.dec_valid, bus.busy, bus.imem_req_valid);
    end
    exp_q.delete();
    req_log.delete();
    req_cyc.delete();
    start = 1'b1;
    expect_entry(32'h0, 2'd0);
    expect_entry(32'h4, 2'd0);
    drain_and_score(2, 20, "after_reset");
  endtask

  initial begin
    start = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_stale();
    test_misaligned();
    test_fault();
    test_wrap_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/stage_if_prefetch.md
Name: stage_if_prefetch

Overview:
- Parametrised successor of the single-cycle fetch stage: decouples PC generation from instruction memory via a valid/ready request/response handshake and an in-order prefetch queue of DEPTH entries.
- Sits between the PC-select logic (redirects from execute/trap unit) and the decode stage; emits pc, pc+4, instruction and trap cause per entry.
- Tracks outstanding memory requests, discards stale responses after a redirect, and stops fetching after a fetch fault until redirected.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, prefetch queue entries (power of 2, >=2).
- MAX_OUTST, 2, max in-flight memory requests (1..DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- start  in  1  synchronous active-low reset (0 = reset, 1 = run).
- redir_valid  in  1  redirect request (branch/jump/trap), one-cycle pulse.
- redir_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response valid (in order, one per request).
- imem_rsp_data  in  32  instruction word.
- imem_rsp_fault  in  1  access fault for this response.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decode accepts head (0 = stall_d).
- dec_pc  out  XLEN  head PC.
- dec_pcplus4  out  XLEN  head PC + 4.
- dec_inst  out  32  head instruction (32'h0000_0013 NOP when trap set).
- dec_trap_valid  out  1  head carries fetch trap.
- dec_trap_cause  out  2  0 none, 1 inst misaligned, 2 inst access fault.
- busy  out  1  outstanding != 0 or queue non-empty.

Behaviour:
- Reset (start=0 at clk edge): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, state=RUN; all outputs 0 except imem_req_addr=RESET_PC.
- States: RUN (issue requests), HALT (fault queued; no issue). RUN->HALT when a misaligned entry is pushed or a faulting response is accepted; HALT->RUN only on redir_valid.
- Issue: imem_req_valid = RUN & !redir_valid & fetch_pc[1:0]==0 & (count+outstanding) < DEPTH & outstanding < MAX_OUTST. On valid&ready: outstanding++, fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Misaligned fetch_pc[1:0]!=0 in RUN: no memory request; push entry {pc=fetch_pc, cause=1} when queue has room counting outstanding, then HALT. Entry is pushed only after all older outstanding responses are pushed (in order).
- Response accepted every cycle imem_rsp_valid=1 (no backpressure; space is reserved at issue). If drop>0: discard, drop--. Else push {pc, data, cause = fault?2:0}; fault -> HALT. Push PC from a per-entry PC tracked in issue order.
- Head: dec_* reflect queue head combinationally from registered queue (no bypass; response-to-dec_valid latency 1 cycle). Pop on dec_valid & dec_ready.
- Redirect (priority over everything same cycle): queue cleared, drop <= outstanding − (response accepted this cycle ? 1:0) (responses this cycle are discarded), outstanding tracking retains count, fetch_pc <= redir_pc, state=RUN; any pop that cycle is ignored by design (decode is flushed). First request to redir_pc issued next cycle.
- Simultaneous issue and response: outstanding unchanged. Simultaneous push and pop on full queue permitted.
- Trap priority: misaligned over access fault; at most one trap entry in queue at a time.
- Reset mid-transaction: counters cleared; responses to pre-reset requests are not expected (memory reset together).

Test Plan:
- Reset then run, imem always ready, 1-cycle response latency, dec_ready=1: requests 0x0,0x4,0x8… back-to-back; dec_pc sequence 0x0,0x4,0x8 with dec_pcplus4 = pc+4.
- dec_ready=0 for 10 cycles, DEPTH=4: exactly 4 entries buffered, imem_req_valid drops; on release entries drain in order 0x0..0xC with no loss or duplicate.
- Redirect to 0x100 with 2 outstanding: both stale responses discarded, next dec_pc = 0x100, no entry from old stream appears.
- Redirect to 0x102: no memory request; one entry pc=0x102, trap_cause=1, inst=0x00000013; fetch halts until next redirect to 0x200 resumes.
- imem_rsp_fault on fetch of 0x8: entry pc=0x8 cause=2; no requests beyond outstanding ones; later redirect resumes.
- fetch_pc=0xFFFF_FFFC: next request addr wraps to 0x0000_0000; start=0 mid-stream clears dec_valid and busy next cycle.
